// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multi-channel PWM generator.
package pwm_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // LSB position of channel ch's duty field in the packed duty bus.
  function automatic int unsigned duty_lsb(input int unsigned ch, input int unsigned width);
    return ch * width;
  endfunction

endpackage

// File: rtl/pwm_cmp.sv
// One PWM channel: compare against the shared counter, apply polarity, register.
module pwm_cmp #(
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 en,
  input  logic [CNT_WIDTH-1:0] cnt_i,
  input  logic [CNT_WIDTH-1:0] duty_i,
  input  logic                 pol_i,
  output logic                 pwm_o
);

  logic pwm_q;
  logic pwm_d;

  always_comb begin
    pwm_d = (cnt_i < duty_i) ^ pol_i;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      pwm_q <= 1'b0;
    end else if (en) begin
      pwm_q <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: staging/shadow config, shared edge/center counter,
// boundary-aligned transfer, and per-channel comparators.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 8,
  parameter int unsigned NUM_CH    = 4
) (
  input  logic                          clk,
  input  logic                          srst,
  input  logic                          en,
  input  logic [CNT_WIDTH-1:0]          period,
  input  logic                          center,
  input  logic [NUM_CH*CNT_WIDTH-1:0]   duty,
  input  logic [NUM_CH-1:0]             pol,
  input  logic                          load,
  output logic                          load_ack,
  output logic                          cycle_start,
  output logic [NUM_CH-1:0]             pwm_o
);

  typedef logic [CNT_WIDTH-1:0] cnt_t;
  localparam cnt_t ONE = cnt_t'(1);

  cnt_t                        period_s_q;
  pwm_mode_e                   mode_s_q;
  logic [NUM_CH*CNT_WIDTH-1:0] duty_s_q;
  logic [NUM_CH-1:0]           pol_s_q;

  cnt_t                        period_l_q;
  pwm_mode_e                   mode_l_q;
  logic [NUM_CH*CNT_WIDTH-1:0] duty_l_q;
  logic [NUM_CH-1:0]           pol_l_q;

  logic pending_q;
  logic ack_arm_q;
  logic load_ack_q;
  logic cycle_start_q;

  cnt_t cnt_q, cnt_d;
  logic dir_q, dir_d;

  logic boundary;
  logic cnt_zero;
  logic transfer;

  assign transfer = boundary & pending_q;

  always_ff @(posedge clk) begin
    if (srst) begin
      period_s_q <= '0;
      mode_s_q   <= PWM_EDGE;
      duty_s_q   <= '0;
      pol_s_q    <= '0;
    end else if (load) begin
      period_s_q <= period;
      mode_s_q   <= center ? PWM_CENTER : PWM_EDGE;
      duty_s_q   <= duty;
      pol_s_q    <= pol;
    end
  end

  // A load coinciding with a transfer keeps pending set so it lands next boundary.
  always_ff @(posedge clk) begin
    if (srst) begin
      pending_q <= 1'b0;
    end else if (load) begin
      pending_q <= 1'b1;
    end else if (transfer) begin
      pending_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      period_l_q <= '0;
      mode_l_q   <= PWM_EDGE;
      duty_l_q   <= '0;
      pol_l_q    <= '0;
    end else if (transfer) begin
      period_l_q <= period_s_q;
      mode_l_q   <= mode_s_q;
      duty_l_q   <= duty_s_q;
      pol_l_q    <= pol_s_q;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_q <= '0;
      dir_q <= DIR_UP;
    end else begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (en) begin
      if (boundary) begin
        cnt_d = '0;
        dir_d = DIR_UP;
      end else if (mode_l_q == PWM_EDGE) begin
        cnt_d = cnt_q + ONE;
      end else if (dir_q == DIR_UP) begin
        if (cnt_q == period_l_q) begin
          cnt_d = cnt_q - ONE;
          dir_d = DIR_DOWN;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end else begin
        cnt_d = cnt_q - ONE;
      end
    end
  end

  always_comb begin
    boundary = 1'b0;
    cnt_zero = (cnt_q == '0);
    if (en) begin
      if (period_l_q == '0) begin
        boundary = 1'b1;
      end else if (mode_l_q == PWM_EDGE) begin
        boundary = (cnt_q == period_l_q);
      end else begin
        boundary = (cnt_q == ONE) && ((dir_q == DIR_DOWN) || (period_l_q == ONE));
      end
    end
  end

  // The ack waits for the first enabled cnt==0 cycle on the new shadow values,
  // so it lines up with that cycle's cycle_start even if en drops in between.
  always_ff @(posedge clk) begin
    if (srst) begin
      ack_arm_q     <= 1'b0;
      load_ack_q    <= 1'b0;
      cycle_start_q <= 1'b0;
    end else begin
      cycle_start_q <= en & cnt_zero;
      load_ack_q    <= en & cnt_zero & ack_arm_q;
      if (transfer) begin
        ack_arm_q <= 1'b1;
      end else if (en && cnt_zero) begin
        ack_arm_q <= 1'b0;
      end
    end
  end

  assign load_ack    = load_ack_q;
  assign cycle_start = cycle_start_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_cmp #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_cmp (
      .clk   (clk),
      .srst  (srst),
      .en    (en),
      .cnt_i (cnt_q),
      .duty_i(duty_l_q[duty_lsb(i, CNT_WIDTH) +: CNT_WIDTH]),
      .pol_i (pol_l_q[i]),
      .pwm_o (pwm_o[i])
    );
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: directed scenarios plus random traffic, checked each
// clock against a position-in-cycle reference model.
module tb_pwm_multi;

  localparam int unsigned W = 8;
  localparam int unsigned N = 4;

  logic           clk = 1'b0;
  logic           srst;
  logic           en;
  logic [W-1:0]   period;
  logic           center;
  logic [N*W-1:0] duty;
  logic [N-1:0]   pol;
  logic           load;
  logic           load_ack;
  logic           cycle_start;
  logic [N-1:0]   pwm_o;

  int tests = 0;
  int fails = 0;
  int acks  = 0;

  pwm_multi #(
    .CNT_WIDTH(W),
    .NUM_CH   (N)
  ) dut (
    .clk        (clk),
    .srst       (srst),
    .en         (en),
    .period     (period),
    .center     (center),
    .duty       (duty),
    .pol        (pol),
    .load       (load),
    .load_ack   (load_ack),
    .cycle_start(cycle_start),
    .pwm_o      (pwm_o)
  );

  always #5 clk = ~clk;

  // Reference model: m_k is the position within the current PWM cycle.
  int         m_k, m_P, m_ctr;
  int         m_D[N];
  bit         m_pol[N];
  int         s_P, s_ctr;
  int         s_D[N];
  bit         s_pol[N];
  bit         m_pend, m_arm;
  logic [N-1:0] e_pwm;
  logic       e_cs, e_ack;

  function automatic int m_len();
    if (m_ctr == 0) return m_P + 1;
    return (m_P == 0) ? 1 : 2 * m_P;
  endfunction

  function automatic int m_cnt();
    if (m_ctr == 0 || m_k <= m_P) return m_k;
    return 2 * m_P - m_k;
  endfunction

  task automatic model_clock();
    int c;
    bit bnd;
    if (srst) begin
      m_k = 0; m_P = 0; m_ctr = 0; s_P = 0; s_ctr = 0;
      for (int i = 0; i < N; i++) begin
        m_D[i] = 0; m_pol[i] = 0; s_D[i] = 0; s_pol[i] = 0;
      end
      m_pend = 0; m_arm = 0;
      e_pwm = '0; e_cs = 1'b0; e_ack = 1'b0;
    end else begin
      c   = m_cnt();
      bnd = en && (m_k == m_len() - 1);
      if (en) begin
        for (int i = 0; i < N; i++)
          e_pwm[i] = ((c < m_D[i]) ? 1'b1 : 1'b0) ^ m_pol[i];
        e_cs  = (c == 0);
        e_ack = (c == 0) && m_arm;
        if (e_ack) m_arm = 0;
      end else begin
        e_cs  = 1'b0;
        e_ack = 1'b0;
      end
      if (bnd) begin
        m_k = 0;
        if (m_pend) begin
          m_P = s_P; m_ctr = s_ctr;
          for (int i = 0; i < N; i++) begin
            m_D[i] = s_D[i]; m_pol[i] = s_pol[i];
          end
          m_pend = 0;
          m_arm  = 1;
        end
      end else if (en) begin
        m_k++;
      end
      if (load) begin
        s_P   = int'(period);
        s_ctr = int'(center);
        for (int i = 0; i < N; i++) begin
          s_D[i]   = int'(duty[i*W +: W]);
          s_pol[i] = pol[i];
        end
        m_pend = 1;
      end
    end
  endtask

  task automatic check();
    tests++;
    assert (pwm_o === e_pwm) else begin
      fails++;
      $error("FAIL pwm_o t=%0t got %b exp %b", $time, pwm_o, e_pwm);
    end
    tests++;
    assert (cycle_start === e_cs) else begin
      fails++;
      $error("FAIL cycle_start t=%0t got %b exp %b", $time, cycle_start, e_cs);
    end
    tests++;
    assert (load_ack === e_ack) else begin
      fails++;
      $error("FAIL load_ack t=%0t got %b exp %b", $time, load_ack, e_ack);
    end
    if (load_ack === 1'b1) acks++;
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    check();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_load(input int p, input bit ctr, input logic [N*W-1:0] d,
                         input logic [N-1:0] pl);
    period = W'(p);
    center = ctr;
    duty   = d;
    pol    = pl;
    load   = 1'b1;
    step();
    load   = 1'b0;
  endtask

  task automatic run_until_cnt(input int c);
    int guard;
    guard = 0;
    while (m_cnt() != c && guard < 200) begin
      step();
      guard++;
    end
    tests++;
    assert (guard < 200) else begin
      fails++;
      $error("FAIL wait_cnt%0d got timeout exp reached", c);
    end
  endtask

  initial begin
    logic [N*W-1:0] rd;
    srst = 1'b1; en = 1'b0; load = 1'b0;
    period = '0; center = 1'b0; duty = '0; pol = '0;
    run(2);
    srst = 1'b0;
    en   = 1'b1;
    run(3);

    // Edge mode, P=9, duties 3/0/10/12
    do_load(9, 1'b0, {8'd12, 8'd10, 8'd0, 8'd3}, 4'b0000);
    run(30);

    // Center mode, P=8, D0=4 inverted
    do_load(8, 1'b1, {8'd0, 8'd0, 8'd0, 8'd4}, 4'b0001);
    run(40);

    // Two loads before one boundary: single ack
    do_load(9, 1'b0, {8'd12, 8'd10, 8'd0, 8'd3}, 4'b0000);
    run(20);
    run_until_cnt(4);
    acks = 0;
    do_load(9, 1'b0, {8'd12, 8'd10, 8'd0, 8'd6}, 4'b0000);
    run_until_cnt(6);
    do_load(9, 1'b0, {8'd12, 8'd10, 8'd0, 8'd7}, 4'b0000);
    run(25);
    tests++;
    assert (acks == 1) else begin
      fails++;
      $error("FAIL double_load_acks got %0d exp 1", acks);
    end

    // Load in the boundary cycle
    run_until_cnt(9);
    do_load(9, 1'b0, {8'd1, 8'd2, 8'd3, 8'd5}, 4'b1010);
    run(25);

    // en low with a load pending
    run_until_cnt(3);
    do_load(9, 1'b0, {8'd9, 8'd4, 8'd2, 8'd8}, 4'b0000);
    en = 1'b0;
    run(5);
    en = 1'b1;
    run(25);

    // Small-period corner cases
    do_load(0, 1'b0, {8'd0, 8'd1, 8'd0, 8'd1}, 4'b0100);
    run(6);
    do_load(1, 1'b1, {8'd0, 8'd1, 8'd2, 8'd1}, 4'b0000);
    run(8);
    do_load(1, 1'b0, {8'd0, 8'd1, 8'd2, 8'd1}, 4'b1000);
    run(8);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) begin
        for (int i = 0; i < N; i++) rd[i*W +: W] = W'($urandom_range(0, 15));
        do_load($urandom_range(0, 12), 1'($urandom_range(0, 1)), rd,
                N'($urandom_range(0, 15)));
      end else begin
        step();
      end
    end

    // Reset mid-cycle with a pending load discards it
    en = 1'b1;
    do_load(9, 1'b0, {8'd12, 8'd10, 8'd0, 8'd3}, 4'b0110);
    run(15);
    do_load(5, 1'b1, {8'd1, 8'd1, 8'd1, 8'd1}, 4'b1111);
    run(2);
    srst = 1'b1;
    step();
    srst = 1'b0;
    acks = 0;
    run(30);
    tests++;
    assert (acks == 0) else begin
      fails++;
      $error("FAIL post_reset_acks got %0d exp 0", acks);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Multi-channel, parametrised PWM generator and the successor to the single-channel pwm block. NUM_CH outputs share one period counter, which supports edge-aligned and center-aligned modes. Each channel has its own duty value and output polarity. All settings pass through staging and shadow registers, so a new configuration takes effect only at a PWM cycle boundary and the outputs are glitch-free. The block sits in the peripheral fabric between the control-register bank and the pad/driver logic (motor phases, LED banks).

## Interface
- CNT_WIDTH, 8: width of the counter, period and each duty value.
- NUM_CH, 4: number of PWM channels; 1..32.
- clk  in  1  clock; all logic on the rising edge.
- srst  in  1  reset: synchronous, active-high.
- en  in  1  count enable; when low the counter, outputs and shadow registers hold.
- period  in  CNT_WIDTH  period value P, captured on load.
- center  in  1  mode, captured on load: 0 = edge-aligned, 1 = center-aligned.
- duty  in  NUM_CH*CNT_WIDTH  per-channel duty D[i] in slice [i*CNT_WIDTH +: CNT_WIDTH], captured on load.
- pol  in  NUM_CH  per-channel polarity, captured on load: 1 inverts the output.
- load  in  1  single-cycle strobe that captures period, center, duty and pol into staging and sets pending.
- load_ack  out  1  one-cycle pulse when staged values become active.
- cycle_start  out  1  one-cycle pulse aligned with the first output cycle of each PWM cycle.
- pwm_o  out  NUM_CH  PWM outputs, registered.

## Operation
- Register sets: staging (written by load) feeds shadow (the active values: P_l, mode_l, D_l[i], pol_l[i]), which drives the counter and comparators.
- Edge mode: cnt runs 0,1,..,P_l, then wraps to 0. Cycle length is P_l+1.
- Center mode: cnt runs 0,1,..,P_l,P_l-1,..,1, then repeats from 0. Cycle length is 2*P_l. A direction bit dir tracks up/down.
- P_l = 0 (either mode): cnt stays at 0 and every enabled cycle is a boundary.
- Boundary cycle is the last count of a cycle, and exists only while en=1:
  - edge: cnt==P_l;
  - center: cnt==1 and (dir==down or P_l==1);
  - also every cycle when P_l==0.
- Output compare: raw[i] = (cnt < D_l[i]); pwm_o[i] <= raw[i] ^ pol_l[i].
- High time per cycle with pol=0:
  - edge: min(D, P+1) cycles;
  - center: 0 if D=0, 2D-1 if 1≤D≤P, 2P if D>P.
- D=0 gives a constant inactive level; D>P (edge) gives a constant active level. Neither case produces a glitch.
- Load: on load=1, staging takes the inputs and pending is set. A second load before transfer overwrites staging; it produces one transfer and one ack.
- Transfer: on a boundary cycle with pending=1 (pending already set in an earlier cycle), shadow takes staging, pending clears, cnt restarts at 0 and dir is set to up.
- A load in the same cycle as a boundary is captured, but it transfers at the next boundary.
- Mode change applies only through a transfer, never mid-cycle.
- en=0: no boundary is recognised, so transfers are deferred. pending and staging are kept. load is still accepted while en=0.

## Timing
- Reset values:
  - cnt=0, dir=up, pending=0;
  - staging and shadow all zero (P_l=0, edge mode, D=0, pol=0);
  - pwm_o=0, load_ack=0, cycle_start=0.
- After reset, P_l=0, so a load at cycle t transfers at t+1.
- Output latency: pwm_o and cycle_start reflect the cnt value of the previous cycle, i.e. 1 clk latency.
- cycle_start=1 in the cycle pwm_o reflects cnt==0.
- load_ack=1 in the same cycle as the first cycle_start that uses the new shadow values.
- srst mid-cycle returns everything to reset values on the next edge. Any pending load is discarded.

## Structure
- Shared package pwm_pkg:
  - mode enum PWM_EDGE/PWM_CENTER;
  - localparams DIR_UP/DIR_DOWN;
  - helper function for the duty slice index.
- Top pwm_multi holds the staging, shadow and pending logic, the counter/direction FSM, the boundary detect, and the ack/cycle_start registers.
- Sub-module pwm_cmp (one per channel, generate loop) holds the compare, polarity XOR and output register.

## Test plan
- Reset then load P=9, edge, D0=3, D1=0, D2=10, D3=12, pol=0 → load_ack after 1 clk. Period is 10 clk. High times: ch0 3, ch1 0, ch2 10, ch3 10. cycle_start every 10 clk.
- Center mode, P=8, D0=4, pol0=1 → period 16 clk; ch0 is low for 7 clk and high for 9 clk, symmetric about cnt==0.
- Running P=9, D0=3; load D0=6 at cnt=4, then load D0=7 at cnt=6 → exactly one load_ack, at the next cycle_start. The old cycle keeps 3 high; the next cycle has 7 high.
- Load in the boundary cycle (cnt==P) → the value is not applied at the immediate wrap; it applies one full cycle later with one ack.
- en low for 5 clk mid-cycle with a load pending → pwm_o and cnt frozen, no ack. After en returns, the cycle resumes and the transfer occurs at its boundary.
- srst asserted mid-cycle with pending=1 → next clk pwm_o=0 and all outputs low. No load_ack afterward without a new load.
